// File: rtl/apb_pkg.sv
// Shared APB definitions: bridge FSM states and the default bus widths
// used by the APB completers on this bus.
package apb_pkg;
    localparam int APB_ADDR_W = 16;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;
endpackage

// File: rtl/apbm_bridge.sv
// APB3 initiator: valid/ready request in, one APB transfer per request,
// held response out, with an optional wait-state timeout abort.
module apbm_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              resp_timeout,
    output logic              apbm_psel,
    output logic              apbm_penable,
    output logic              apbm_pwrite,
    output logic [ADDR_W-1:0] apbm_paddr,
    output logic [DATA_W-1:0] apbm_pwdata,
    input  logic [DATA_W-1:0] apbm_prdata,
    input  logic              apbm_pready,
    input  logic              apbm_pslverr
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    apb_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_resp_valid, r_resp_err, r_resp_to;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              w_accept, w_done, w_abort;

    assign w_accept = req_valid && req_ready;
    assign w_done   = (r_state == ST_ACCESS) && apbm_pready;

    // r_cnt counts ACCESS cycles already spent without pready; abort when
    // the current cycle would be the TIMEOUT-th such cycle.
    generate
        if (TIMEOUT > 0) begin : g_to
            assign w_abort = (r_state == ST_ACCESS) && !apbm_pready &&
                             (r_cnt == CNT_W'(TIMEOUT - 1));
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    r_cnt <= '0;
                else if ((r_state == ST_ACCESS) && !apbm_pready && !w_abort)
                    r_cnt <= r_cnt + 1'b1;
                else
                    r_cnt <= '0;
            end
        end else begin : g_no_to
            assign w_abort = 1'b0;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_cnt <= '0;
                else     r_cnt <= '0;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (w_done || w_abort) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Strobes decode straight from the state register so reset drops them at once.
    always_comb begin
        apbm_psel    = (r_state != ST_IDLE);
        apbm_penable = (r_state == ST_ACCESS);
        req_ready    = (r_state == ST_IDLE) && (!r_resp_valid || resp_ready) && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
        end else if (w_accept) begin
            r_pwrite <= req_write;
            r_paddr  <= req_addr;
            r_pwdata <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_resp_to    <= 1'b0;
        end else if (w_done) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_pwrite ? '0 : apbm_prdata;
            r_resp_err   <= apbm_pslverr;
            r_resp_to    <= 1'b0;
        end else if (w_abort) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b1;
            r_resp_to    <= 1'b1;
        end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign apbm_pwrite  = r_pwrite;
    assign apbm_paddr   = r_paddr;
    assign apbm_pwdata  = r_pwdata;
    assign resp_valid   = r_resp_valid;
    assign resp_rdata   = r_resp_rdata;
    assign resp_err     = r_resp_err;
    assign resp_timeout = r_resp_to;
endmodule

// File: tb/tb_apbm_bridge.sv
// Directed plus randomized bench for apbm_bridge; the completer is driven
// inline and each expected response follows from the transfer's parameters.
module tb_apbm_bridge;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0, req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_ready = 1'b1;
    logic          req_ready, resp_valid, resp_err, resp_timeout;
    logic [DW-1:0] resp_rdata;
    logic          apbm_psel, apbm_penable, apbm_pwrite;
    logic [AW-1:0] apbm_paddr;
    logic [DW-1:0] apbm_pwdata;
    logic [DW-1:0] apbm_prdata = '0;
    logic          apbm_pready = 1'b0, apbm_pslverr = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] last_rdata;
    logic          last_err, last_to;

    always #5 clk = ~clk;

    apbm_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_timeout(resp_timeout),
        .apbm_psel(apbm_psel), .apbm_penable(apbm_penable), .apbm_pwrite(apbm_pwrite),
        .apbm_paddr(apbm_paddr), .apbm_pwdata(apbm_pwdata), .apbm_prdata(apbm_prdata),
        .apbm_pready(apbm_pready), .apbm_pslverr(apbm_pslverr)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transfer. waits = wait states before pready; waits >= TO means
    // the completer never answers in time and the bridge must abort.
    task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int waits, input bit err, input logic [DW-1:0] rd);
        int  cyc;
        bit  exp_to;
        int  n_access;
        exp_to = (waits >= TO);
        resp_ready = 1'b1;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
        #1;
        cyc = 0;
        while (!req_ready && cyc < 20) begin tick(); cyc++; end
        chk("accept_latency", 32'(cyc), 32'd0);
        tick();
        req_valid = 1'b0; req_write = $urandom_range(0, 1);
        req_addr = AW'($urandom); req_wdata = $urandom;
        chk("setup_psel", 32'(apbm_psel), 32'd1);
        chk("setup_penable", 32'(apbm_penable), 32'd0);
        chk("setup_paddr", 32'(apbm_paddr), 32'(a));
        chk("setup_pwrite", 32'(apbm_pwrite), 32'(wr));
        chk("setup_pwdata", apbm_pwdata, wd);
        chk("setup_resp_valid", 32'(resp_valid), 32'd0);
        tick();
        n_access = exp_to ? TO : waits + 1;
        for (int k = 0; k < n_access; k++) begin
            chk("access_psel", 32'(apbm_psel), 32'd1);
            chk("access_penable", 32'(apbm_penable), 32'd1);
            chk("access_paddr", 32'(apbm_paddr), 32'(a));
            chk("access_pwdata", apbm_pwdata, wd);
            chk("access_resp_valid", 32'(resp_valid), 32'd0);
            if (!exp_to && k == waits) begin
                apbm_pready = 1'b1; apbm_pslverr = err; apbm_prdata = rd;
            end else begin
                apbm_pready = 1'b0; apbm_pslverr = $urandom_range(0, 1);
                apbm_prdata = $urandom;
            end
            tick();
        end
        apbm_pready = 1'b0; apbm_pslverr = 1'b0; apbm_prdata = $urandom;
        last_rdata = (exp_to || wr) ? '0 : rd;
        last_err   = exp_to ? 1'b1 : err;
        last_to    = exp_to;
        chk("resp_psel", 32'(apbm_psel), 32'd0);
        chk("resp_penable", 32'(apbm_penable), 32'd0);
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_rdata", resp_rdata, last_rdata);
        chk("resp_err", 32'(resp_err), 32'(last_err));
        chk("resp_timeout", 32'(resp_timeout), 32'(last_to));
        chk("idle_paddr_hold", 32'(apbm_paddr), 32'(a));
    endtask

    initial begin
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_psel", 32'(apbm_psel), 32'd0);
        chk("rst_penable", 32'(apbm_penable), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_paddr", 32'(apbm_paddr), 32'd0);
        chk("rst_pwdata", apbm_pwdata, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_timeout", 32'(resp_timeout), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        xfer(1'b1, 16'h0004, 32'hDEADBEEF, 0, 1'b0, 32'h0);
        xfer(1'b0, 16'h0010, 32'h0, 3, 1'b0, 32'h12345678);
        xfer(1'b1, 16'h0020, 32'hCAFEF00D, 1, 1'b1, 32'h0);
        xfer(1'b0, 16'h0024, 32'h0, 2, 1'b1, 32'hA5A5A5A5);
        xfer(1'b0, 16'h0030, 32'h0, 100, 1'b0, 32'h0);
        xfer(1'b0, 16'h0034, 32'h0, 0, 1'b0, 32'h0BADC0DE);

        // Backpressure: pending response blocks the next request.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0040; req_wdata = 32'h11223344;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_psel", 32'(apbm_psel), 32'd0);
            chk("bp_resp_valid", 32'(resp_valid), 32'd1);
            chk("bp_resp_rdata", resp_rdata, last_rdata);
            chk("bp_resp_err", 32'(resp_err), 32'(last_err));
            tick();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        xfer(1'b1, 16'h0040, 32'h11223344, 0, 1'b0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            xfer(1'($urandom_range(0, 1)), AW'($urandom), $urandom,
                 int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0), $urandom);
        end

        // Reset in the middle of ACCESS.
        resp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0050;
        #1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("pre_rst_penable", 32'(apbm_penable), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_psel", 32'(apbm_psel), 32'd0);
        chk("midrst_penable", 32'(apbm_penable), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("postrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("postrst_req_ready", 32'(req_ready), 32'd1);
        tick();
        chk("postrst_psel", 32'(apbm_psel), 32'd0);
        chk("postrst_resp_valid2", 32'(resp_valid), 32'd0);
        xfer(1'b0, 16'h0060, 32'h0, 1, 1'b0, 32'h600DF00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
